// File: rtl/pc_flag_if.sv
// Control/status bundle between the decoder and the PC/flag block of the WISC core.
// Handshake: there is no valid/ready pair. Every control field counts as valid in every
// cycle. Only 'stall' can hold the block, and it is sampled on the rising clock edge.
interface pc_flag_if;
  logic        stall;
  logic        branch;
  logic        br_reg;
  logic [1:0]  pcs;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] rs_data;
  logic [2:0]  flag_we;
  logic [2:0]  alu_flags;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        taken;
  logic        halted;
  logic        dbg_state;

  modport master (
    output stall, branch, br_reg, pcs, cond, imm9, rs_data, flag_we, alu_flags,
    input  pc, pc_plus2, flags, taken, halted, dbg_state
  );

  modport slave (
    input  stall, branch, br_reg, pcs, cond, imm9, rs_data, flag_we, alu_flags,
    output pc, pc_plus2, flags, taken, halted, dbg_state
  );
endinterface

// File: rtl/pc_flag_control.sv
// Owns the architectural PC, the Z/V/N flag register and the sticky HLT state.
// It selects the next PC from the sequential, B (relative) and BR (register) paths.
module pc_flag_control #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_flag_if.slave  bus
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  flags_q, flags_d;

    logic [15:0] pc_plus2;
    logic [15:0] target;
    logic        flag_z, flag_v, flag_n;
    logic        cond_true;
    logic        taken;

    assign pc_plus2 = pc_q + 16'(PC_STEP);
    assign flag_z   = flags_q[2];
    assign flag_v   = flags_q[1];
    assign flag_n   = flags_q[0];

    // Conditions look only at the registered flags, never at this cycle's ALU result.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | ~flag_n;
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    assign taken  = bus.branch & cond_true & (state_q != ST_HALT);
    assign target = bus.br_reg ? bus.rs_data
                               : pc_plus2 + {{6{bus.imm9[8]}}, bus.imm9, 1'b0};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (state_q == ST_HALT || bus.stall) begin
            state_d = state_q;
        end else if (bus.pcs == 2'b11) begin
            state_d = ST_HALT;
        end else begin
            pc_d = taken ? target : pc_plus2;
            for (int i = 0; i < 3; i++) begin
                if (bus.flag_we[i]) flags_d[i] = bus.alu_flags[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus2  = pc_plus2;
    assign bus.flags     = flags_q;
    assign bus.taken     = taken;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.dbg_state = state_q;

endmodule
